// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 valid/ready stream mux, fixed or round-robin select, registered output.
// Define STREAM_MUX_LOCK_EN to add in_last/out_last and lock the grant for a whole packet.

module stream_mux_rr_lane #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_valid,
  output logic             o_req,
  output logic [SEL_W:0]   o_dist
);
  localparam logic [SEL_W:0] IDX_V = (SEL_W+1)'(IDX);
  localparam logic [SEL_W:0] N_V   = (SEL_W+1)'(N_CH);

  logic [SEL_W:0] w_ptr;

  assign w_ptr  = {1'b0, i_ptr};
  // Distance from the rr pointer to this lane, wrapping at N_CH (not 2**SEL_W).
  assign o_dist = (IDX_V >= w_ptr) ? (IDX_V - w_ptr) : (IDX_V + N_V - w_ptr);
  assign o_req  = i_valid;
endmodule

module stream_mux_rr #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [N_CH-1:0]       i_in_valid,
  input  logic [N_CH*WIDTH-1:0] i_in_data,
  output logic [N_CH-1:0]       o_in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [N_CH-1:0]       i_in_last,
  output logic                  o_out_last,
`endif
  output logic                  o_out_valid,
  output logic [WIDTH-1:0]      o_out_data,
  output logic [SEL_W-1:0]      o_out_ch,
  input  logic                  i_out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] ch;
`ifdef STREAM_MUX_LOCK_EN
    logic             last;
`endif
  } beat_t;

  logic [N_CH-1:0][WIDTH-1:0] w_in_data;
  logic [N_CH-1:0]            w_req;
  logic [N_CH-1:0][SEL_W:0]   w_dist;
  logic                       r_vld;
  beat_t                      r_beat;
  beat_t                      w_beat;
  logic [SEL_W-1:0]           r_ptr;
  logic                       w_rr_hit, w_fix_hit, w_hit;
  logic [SEL_W-1:0]           w_rr_g, w_g, w_ptr_nxt;
  logic [SEL_W:0]             w_rr_best;
  logic                       w_load, w_xfer, w_ptr_upd;

  assign w_in_data = i_in_data;

  function automatic logic ch_valid(input logic [SEL_W-1:0] idx, input logic [N_CH-1:0] vld);
    ch_valid = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (idx == SEL_W'(i) && vld[i]) ch_valid = 1'b1;
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    stream_mux_rr_lane #(.N_CH(N_CH), .SEL_W(SEL_W), .IDX(gi)) u_lane (
      .i_ptr  (r_ptr),
      .i_valid(i_in_valid[gi]),
      .o_req  (w_req[gi]),
      .o_dist (w_dist[gi])
    );
  end

  always_comb begin
    w_rr_hit  = 1'b0;
    w_rr_g    = '0;
    w_rr_best = '1;
    for (int i = 0; i < N_CH; i++)
      if (w_req[i] && (!w_rr_hit || w_dist[i] < w_rr_best)) begin
        w_rr_hit  = 1'b1;
        w_rr_best = w_dist[i];
        w_rr_g    = SEL_W'(i);
      end
  end

  // An out-of-range sel matches no lane, so it simply grants nobody.
  assign w_fix_hit = ch_valid(i_sel, i_in_valid);

`ifdef STREAM_MUX_LOCK_EN
  logic             r_locked;
  logic [SEL_W-1:0] r_lock_ch;
`endif

  always_comb begin
    w_hit = 1'b0;
    w_g   = '0;
`ifdef STREAM_MUX_LOCK_EN
    if (r_locked) begin
      w_hit = ch_valid(r_lock_ch, i_in_valid);
      w_g   = r_lock_ch;
    end else
`endif
    if (i_mode) begin
      w_hit = w_rr_hit;
      w_g   = w_rr_g;
    end else begin
      w_hit = w_fix_hit;
      w_g   = i_sel;
    end
  end

  assign w_load = !r_vld || i_out_ready;
  assign w_xfer = w_hit && w_load;

  always_comb begin
    o_in_ready = '0;
    w_beat     = '0;
    w_beat.ch  = w_g;
    for (int i = 0; i < N_CH; i++)
      if (w_g == SEL_W'(i)) begin
        o_in_ready[i] = w_xfer && i_rst_n;
        w_beat.data   = w_in_data[i];
`ifdef STREAM_MUX_LOCK_EN
        w_beat.last   = i_in_last[i];
`endif
      end
  end

  assign w_ptr_nxt = (w_g == SEL_W'(N_CH-1)) ? '0 : w_g + 1'b1;
`ifdef STREAM_MUX_LOCK_EN
  assign w_ptr_upd = w_xfer && i_mode && w_beat.last;
`else
  assign w_ptr_upd = w_xfer && i_mode;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_beat <= '0;
      r_ptr  <= '0;
    end else begin
      if (w_xfer) begin
        r_vld  <= 1'b1;
        r_beat <= w_beat;
      end else if (i_out_ready) begin
        r_vld  <= 1'b0;
      end
      if (w_ptr_upd) r_ptr <= w_ptr_nxt;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_locked  <= !w_beat.last;
      r_lock_ch <= w_g;
    end
  end

  assign o_out_last = r_beat.last;
`endif

  assign o_out_valid = r_vld;
  assign o_out_data  = r_beat.data;
  assign o_out_ch    = r_beat.ch;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: beat-level reference model on a 4-channel instance, directed
// checks on a 3-channel instance; lock checks when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           mode = 1'b0, out_ready = 1'b1;
  logic [1:0]     sel = '0;
  logic [N-1:0]   in_valid = '1, in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;

  logic           b_mode = 1'b0, b_out_ready = 1'b1;
  logic [1:0]     b_sel = '0;
  logic [2:0]     b_valid = '1, b_ready;
  logic [23:0]    b_data = '0;
  logic           b_ovalid;
  logic [7:0]     b_odata;
  logic [1:0]     b_och;

`ifdef STREAM_MUX_LOCK_EN
  logic [N-1:0]   in_last = '1;
  logic           out_last;
  logic [2:0]     b_last = '1;
  logic           b_olast;
`endif

  stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_sel(sel),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .i_in_last(in_last), .o_out_last(out_last),
`endif
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_ch(out_ch),
    .i_out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(b_mode), .i_sel(b_sel),
    .i_in_valid(b_valid), .i_in_data(b_data), .o_in_ready(b_ready),
`ifdef STREAM_MUX_LOCK_EN
    .i_in_last(b_last), .o_out_last(b_olast),
`endif
    .o_out_valid(b_ovalid), .o_out_data(b_odata), .o_out_ch(b_och),
    .i_out_ready(b_out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the beat held in the output register plus the arbitration state.
  bit         m_vld;
  logic [7:0] m_data;
  int         m_ch, m_ptr;
  bit         m_last, m_lock;
  int         m_lch;

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_last = 0; m_lock = 0; m_lch = 0;
  endtask

  // Check the 4-channel DUT against the model at negedge, then advance the model at posedge.
  task automatic tick();
    int g;
    bit ld, lst;
    logic [N-1:0] er;
    @(negedge clk);
    if (!rst_n) model_reset();
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef STREAM_MUX_LOCK_EN
    chk("out_last", 32'(out_last), 32'(m_last));
`endif
    g = -1;
    if (m_lock) begin
      if (in_valid[m_lch]) g = m_lch;
    end else if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    ld = !m_vld || out_ready;
    er = '0;
    if (rst_n && g >= 0 && ld) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    lst = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
    if (g >= 0) lst = in_last[g];
`endif
    @(posedge clk);
    if (rst_n) begin
      if (g >= 0 && ld) begin
        m_vld  = 1;
        m_data = in_data[g*W +: W];
        m_ch   = g;
`ifdef STREAM_MUX_LOCK_EN
        m_last = lst;
        m_lock = !lst;
        m_lch  = g;
`endif
        if (mode && lst) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset with every channel requesting.
    mode = 1'b1;
    b_mode = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_b_in_ready", 32'(b_ready), 32'h0);
    rst_n = 1'b1;
    b_valid = '0;

    // Fixed select of channel 2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h11A52233;
    #1 chk("fix_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("fix_out_valid", 32'(out_valid), 32'h1);
    chk("fix_out_data", 32'(out_data), 32'hA5);
    chk("fix_out_ch", 32'(out_ch), 32'h2);

    // Round-robin over all-valid channels from a fresh pointer.
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h13121110; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_out_ch", 32'(out_ch), 32'(k % 4));
      chk("rr_out_data", 32'(out_data), 32'(8'h10 + k % 4));
    end

    // Backpressure holds the beat, then full rate resumes in order.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_ch", 32'(out_ch), 32'h3);
      chk("bp_out_data", 32'(out_data), 32'h13);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rel_out_ch", 32'(out_ch), 32'(k));
    end

    // Three-channel instance: out-of-range sel, then wrap-around arbitration.
    in_valid = '0;
    do_reset();
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111; b_data = 24'hC2C1C0;
    #1 chk("n3_sel3_ready", 32'(b_ready), 32'h0);
    tick();
    chk("n3_sel3_valid", 32'(b_ovalid), 32'h0);
    b_mode = 1'b1; b_valid = 3'b001;
    #1 chk("n3_ch0_ready", 32'(b_ready), 32'b001);
    tick();
    chk("n3_ch0_out", 32'(b_och), 32'h0);
    b_valid = 3'b101;
    #1 chk("n3_ptr1_ready", 32'(b_ready), 32'b100);
    tick();
    chk("n3_ptr1_ch", 32'(b_och), 32'h2);
    chk("n3_ptr1_data", 32'(b_odata), 32'hC2);
    #1 chk("n3_wrap_ready", 32'(b_ready), 32'b001);
    tick();
    chk("n3_wrap_ch", 32'(b_och), 32'h0);
    chk("n3_wrap_data", 32'(b_odata), 32'hC0);
    b_valid = '0;

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock: ch1 sends three beats while ch0 keeps requesting.
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_last = 4'b1111; in_valid = 4'b0001;
    tick();
    in_valid = 4'b0011; in_last = 4'b1101;
    tick();
    chk("lk_b1_ch", 32'(out_ch), 32'h1);
    chk("lk_b1_last", 32'(out_last), 32'h0);
    tick();
    chk("lk_b2_ch", 32'(out_ch), 32'h1);
    chk("lk_b2_last", 32'(out_last), 32'h0);
    in_last = 4'b1111;
    tick();
    chk("lk_b3_ch", 32'(out_ch), 32'h1);
    chk("lk_b3_last", 32'(out_last), 32'h1);
    tick();
    chk("lk_after_ch", 32'(out_ch), 32'h0);
`endif

    // Randomized traffic against the model, with occasional mid-stream resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LOCK_EN
      in_last   = 4'($urandom);
`endif
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
